// File: rtl/mask_generator_pkg.sv
// Shared GA definitions: LFSR polynomial, default seed, mask FSM encoding.
package mask_generator_pkg;

  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2345;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // One right shift of the Galois LFSR; taps fold in when bit 0 falls out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/mask_generator_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load and advance enable.
module lfsr32
  import mask_generator_pkg::*;
#(
  parameter logic [31:0] SeedValue = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        en,
  output logic [31:0] value
);

  // A zero state would lock the LFSR, so a zero seed falls back to the default.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       value <= SeedValue;
    else if (load) value <= (seed == 32'h0) ? SeedValue : seed;
    else if (en)   value <= lfsr_step(value);
  end

endmodule

// File: rtl/mask_generator.sv
// Builds one crossover mask and two mutation masks per request, one bit per
// GEN cycle from the LFSR, and holds them until the consumer accepts.
module mask_generator
  import mask_generator_pkg::*;
#(
  parameter int          Width     = 32,
  parameter logic [31:0] SeedValue = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [31:0]      seed,
  input  logic             start,
  input  logic [7:0]       mutation_rate,
  input  logic             uniform,
  output logic             busy,
  output logic             valid,
  input  logic             ready,
  output logic [Width-1:0] crossover_mask,
  output logic [Width-1:0] daughter_mutation_mask,
  output logic [Width-1:0] son_mutation_mask
);

  localparam int CW = $clog2(Width);

  if (Width < 2 || Width > 256 || (Width & (Width - 1)) != 0) begin : g_bad_width
    $error("mask_generator: Width must be a power of two in 2..256");
  end

  state_t        state;
  logic          go;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cut;
  logic [7:0]    rate;
  logic          uni;
  logic [31:0]   lfsr;

  logic          idle_free;
  logic          seed_take;
  logic          gen;
  logic          last;
  logic [CW-1:0] cut_now;
  logic          xo_bit;
  logic          dm_bit;
  logic          sm_bit;
  logic          lfsr_unused;

  // go marks the arm cycle between accepting start and entering GEN; it lets a
  // seed loaded alongside start be the very first LFSR value used.
  assign idle_free = (state == IDLE) && !go;
  assign seed_take = idle_free && seed_load;
  assign gen       = (state == GEN);
  assign last      = (cnt == CW'(Width - 1));

  // Cut point is taken from the first GEN value and frozen for the rest.
  assign cut_now = (cnt == '0) ? lfsr[24 +: CW] : cut;
  assign xo_bit  = uni ? lfsr[16] : (cnt < cut_now);
  assign dm_bit  = lfsr[7:0]  < rate;
  assign sm_bit  = lfsr[15:8] < rate;

  assign lfsr_unused = ^lfsr;

  lfsr32 #(.SeedValue(SeedValue)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (seed_take),
    .seed  (seed),
    .en    (gen),
    .value (lfsr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= IDLE;
      go                     <= 1'b0;
      cnt                    <= '0;
      cut                    <= '0;
      rate                   <= '0;
      uni                    <= 1'b0;
      busy                   <= 1'b0;
      valid                  <= 1'b0;
      crossover_mask         <= '0;
      daughter_mutation_mask <= '0;
      son_mutation_mask      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state                  <= GEN;
            go                     <= 1'b0;
            busy                   <= 1'b1;
            cnt                    <= '0;
            crossover_mask         <= '0;
            daughter_mutation_mask <= '0;
            son_mutation_mask      <= '0;
          end else if (start) begin
            go   <= 1'b1;
            rate <= mutation_rate;
            uni  <= uniform;
          end
        end
        GEN: begin
          crossover_mask[cnt]         <= xo_bit;
          daughter_mutation_mask[cnt] <= dm_bit;
          son_mutation_mask[cnt]      <= sm_bit;
          if (cnt == '0) cut <= cut_now;
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= HOLD;
            busy  <= 1'b0;
            valid <= 1'b1;
          end
        end
        HOLD: begin
          if (ready) begin
            state <= IDLE;
            valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mask_generator.sv
// Scoreboard bench for mask_generator: a reference LFSR builds expected masks
// at issue time; a negedge monitor checks each presented set and its timing.
module tb_mask_generator;

  localparam int          W    = 32;
  localparam logic [31:0] DSEED = 32'hACE1_2345;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         seed_load = 1'b0;
  logic [31:0]  seed = '0;
  logic         start = 1'b0;
  logic [7:0]   mutation_rate = '0;
  logic         uniform = 1'b0;
  logic         busy;
  logic         valid;
  logic         ready = 1'b1;
  logic [W-1:0] crossover_mask;
  logic [W-1:0] daughter_mutation_mask;
  logic [W-1:0] son_mutation_mask;

  mask_generator #(.Width(W), .SeedValue(DSEED)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .seed_load              (seed_load),
    .seed                   (seed),
    .start                  (start),
    .mutation_rate          (mutation_rate),
    .uniform                (uniform),
    .busy                   (busy),
    .valid                  (valid),
    .ready                  (ready),
    .crossover_mask         (crossover_mask),
    .daughter_mutation_mask (daughter_mutation_mask),
    .son_mutation_mask      (son_mutation_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] xo;
    logic [W-1:0] dm;
    logic [W-1:0] sm;
    int           t;
  } exp_t;

  exp_t         sbq[$];
  int           checks = 0;
  int           fails  = 0;
  int           cyc    = 0;
  logic [31:0]  m_lfsr = DSEED;
  logic [W-1:0] last_xo, last_dm, last_sm;
  logic [W-1:0] first_xo, first_dm, first_sm;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  // Drive one request cycle; the reference LFSR follows the same requests.
  task automatic issue(input bit do_seed, input logic [31:0] sd, input bit do_start,
                       input logic [7:0] r, input bit u);
    exp_t        e;
    logic [31:0] l;
    int          p;
    @(negedge clk);
    seed_load = do_seed; seed = sd; start = do_start; mutation_rate = r; uniform = u;
    if (do_seed) m_lfsr = (sd == 32'h0) ? DSEED : sd;
    if (do_start) begin
      e.xo = '0; e.dm = '0; e.sm = '0; p = 0;
      for (int k = 0; k < W; k++) begin
        l = m_lfsr;
        if (k == 0) p = int'(l[31:24]) & (W - 1);
        e.dm[k] = (l[7:0]  < r);
        e.sm[k] = (l[15:8] < r);
        e.xo[k] = u ? l[16] : (k < p);
        m_lfsr  = step(m_lfsr);
      end
      e.t = cyc + 1;
      sbq.push_back(e);
    end
    @(negedge clk);
    seed_load = 1'b0; start = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!valid && n < 200) begin @(negedge clk); n++; end
    if (!valid) begin
      checks++; fails++;
      $display("FAIL %s_timeout actual=no_valid required=valid_within_200", nm);
    end
    @(negedge clk);
  endtask

  // Monitor: pop on each valid rise, then demand stability while valid stays up.
  logic         valid_q = 1'b0;
  int           busy_cnt = 0;
  logic [W-1:0] h_xo, h_dm, h_sm;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      valid_q  = 1'b0;
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (valid && !valid_q) begin
        if (sbq.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_valid actual=valid required=no_pending_request");
        end else begin
          e = sbq.pop_front();
          chk("crossover_mask", 64'(crossover_mask), 64'(e.xo));
          chk("daughter_mask", 64'(daughter_mutation_mask), 64'(e.dm));
          chk("son_mask", 64'(son_mutation_mask), 64'(e.sm));
          chk("valid_latency", 64'(cyc), 64'(e.t + W + 1));
          chk("busy_cycles", 64'(busy_cnt), 64'(W));
        end
        last_xo = crossover_mask; last_dm = daughter_mutation_mask; last_sm = son_mutation_mask;
        h_xo = crossover_mask; h_dm = daughter_mutation_mask; h_sm = son_mutation_mask;
        busy_cnt = 0;
      end else if (valid) begin
        chk("hold_stable", 64'({crossover_mask, daughter_mutation_mask}), 64'({h_xo, h_dm}));
        chk("hold_stable_son", 64'(son_mutation_mask), 64'(h_sm));
      end
      valid_q = valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_xo", 64'(crossover_mask), 64'(0));
    chk("rst_dm", 64'(daughter_mutation_mask), 64'(0));
    chk("rst_sm", 64'(son_mutation_mask), 64'(0));
    rst = 1'b0;

    // Uniform, rate 0: crossover follows LFSR bit 16 (ACE12345 -> 1, D65091A1 -> 0).
    issue(0, 0, 1, 8'd0, 1);
    wait_valid("run1");
    chk("run1_xo_low2", 64'(last_xo[1:0]), 64'(2'b01));
    chk("run1_dm_zero", 64'(last_dm), 64'(0));
    first_xo = last_xo; first_dm = last_dm; first_sm = last_sm;

    // Zero seed restores the default; cut = 0xAC & 31 = 12.
    issue(1, 32'h0, 0, 8'd0, 0);
    issue(0, 0, 1, 8'd255, 0);
    wait_valid("run2");
    chk("run2_xo_cut12", 64'(last_xo), 64'(32'h0000_0FFF));

    // Seed and start together; top byte 0 gives an empty single-point mask.
    issue(1, 32'h00AB_CDEF, 1, 8'd255, 0);
    wait_valid("run3");
    chk("run3_xo_cut0", 64'(last_xo), 64'(0));
    chk("run3_bit0_dm_sm", 64'({last_dm[0], last_sm[0]}), 64'(2'b11));

    // Cut 31 with FF bytes at k=0; consumer stalls for 10 cycles.
    ready = 1'b0;
    issue(1, 32'h1F00_FFFF, 1, 8'd255, 0);
    wait_valid("run4");
    chk("run4_xo_cut31", 64'(last_xo), 64'(32'h7FFF_FFFF));
    chk("run4_bit0_ff", 64'({last_dm[0], last_sm[0]}), 64'(2'b00));
    repeat (4) @(negedge clk);
    start = 1'b1; seed_load = 1'b1; seed = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; seed_load = 1'b0;
    repeat (5) @(negedge clk);
    chk("hold_valid_up", 64'(valid), 64'(1));
    ready = 1'b1;
    @(negedge clk);
    chk("accept_to_idle", 64'(valid), 64'(0));
    repeat (3) @(negedge clk);
    chk("hold_start_ignored", 64'(busy), 64'(0));

    // Abort in GEN cycle 5, then a fresh run must match the first one.
    issue(0, 0, 1, 8'd0, 1);
    repeat (5) @(negedge clk);
    chk("mid_gen_busy", 64'(busy), 64'(1));
    #1 rst = 1'b1;
    #1;
    chk("abort_outputs", 64'({busy, valid}), 64'(0));
    chk("abort_masks", 64'(crossover_mask | daughter_mutation_mask | son_mutation_mask), 64'(0));
    void'(sbq.pop_back());
    m_lfsr = DSEED;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(0, 0, 1, 8'd0, 1);
    wait_valid("rerun");
    chk("rerun_same_xo", 64'(last_xo), 64'(first_xo));
    chk("rerun_same_mut", 64'({last_dm, last_sm}), 64'({first_dm, first_sm}));

    // Rate and mode change mid-GEN must not reach this run's masks.
    issue(0, 0, 1, 8'd0, 1);
    repeat (3) @(negedge clk);
    mutation_rate = 8'd255; uniform = 1'b0;
    wait_valid("ratechg");
    chk("ratechg_mut_zero", 64'({last_dm, last_sm}), 64'(0));

    // Density at rate 64; 100 runs is a short sample so the band is wider than 0.01.
    ones = 0;
    issue(1, 32'h1234_5678, 0, 8'd0, 0);
    for (int i = 0; i < 100; i++) begin
      issue(0, 0, 1, 8'd64, i[0]);
      wait_valid("density");
      ones += $countones(last_dm) + $countones(last_sm);
    end
    chk("density_band", 64'((ones >= 1408) && (ones <= 1792)), 64'(1));
    chk("sb_drained", 64'(sbq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/mask_generator.md
MASK_GENERATOR -- requirements
Module: mask_generator

Interface
REQ-001 Parameter Width, default 32: chromosome width; SHALL be a power of two, 2..256.
REQ-002 Parameter SeedValue, default 32'hACE12345: LFSR reset seed; nonzero.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 seed_load  input  1  load seed into LFSR (honoured in IDLE only).
REQ-006 seed  input  32  seed value; zero SHALL be replaced by SeedValue.
REQ-007 start  input  1  request one mask set (honoured in IDLE only).
REQ-008 mutation_rate  input  8  per-bit mutation probability = rate/256.
REQ-009 uniform  input  1  1 = uniform crossover, 0 = single-point crossover.
REQ-010 busy  output  1  high in GEN.
REQ-011 valid  output  1  high in HOLD; mask set available.
REQ-012 ready  input  1  consumer accepts mask set when valid.
REQ-013 crossover_mask  output  Width  feeds the crossover/mutation stage.
REQ-014 daughter_mutation_mask  output  Width  XOR mask for daughter.
REQ-015 son_mutation_mask  output  Width  XOR mask for son.

Function
REQ-016 LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (tap mask 32'h80200003), shifting right; advances exactly once per GEN cycle, holds otherwise.
REQ-017 States IDLE, GEN, HOLD; IDLE->GEN on start; GEN->HOLD after Width GEN cycles; HOLD->IDLE on ready.
REQ-018 On start in IDLE, mutation_rate and uniform SHALL be registered; later changes are ignored until the next start.
REQ-019 GEN cycle k (k = 0..Width-1) uses the pre-advance LFSR value L to write bit k of each mask.
REQ-020 daughter bit k = (L[7:0] < rate); son bit k = (L[15:8] < rate); unsigned 8-bit compare.
REQ-021 Uniform mode: crossover bit k = L[16].
REQ-022 Single-point mode: cut point p = L[31:24] & (Width-1), captured at k = 0; crossover bit k = (k < p); p = 0 yields an all-zero mask.
REQ-023 Latency: start sampled at edge T; valid rises at edge T+Width+1; busy is high for exactly Width cycles.
REQ-024 Masks SHALL stay stable from valid rise to acceptance; valid&&ready in HOLD returns to IDLE on the same edge; start is not accepted in that cycle.
REQ-025 start or seed_load outside IDLE SHALL be ignored; start and seed_load together in IDLE: seed loads, and GEN begins next edge using the new seed.
REQ-026 rate = 0 SHALL give all-zero mutation masks; rate = 255 SHALL set a bit unless the byte is 8'hFF.
REQ-027 Mask bits not yet written in GEN are 0; masks are cleared on entering GEN.

Reset
REQ-028 rst asserted: state IDLE, LFSR = SeedValue, all masks 0, busy 0, valid 0, registered rate 0, uniform 0, counter 0.
REQ-029 rst mid-GEN or mid-HOLD SHALL abort immediately; no partial mask is ever presented with valid = 1.
REQ-030 Reset release is synchronised by the system; the block itself needs no release logic.

Structure
REQ-031 Shared GA package holds: the LFSR tap constant, the default seed, and the state encoding (IDLE = 0, GEN = 1, HOLD = 2).
REQ-032 One sub-module, lfsr32 (seed load, enable, value out), instantiated once; the FSM, bit counter and mask registers are in mask_generator.

Verification
REQ-033 Reset, then start with rate = 0, uniform = 1, ready = 1 -> valid at cycle Width+1, both mutation masks 0, crossover_mask equal to the golden-model LFSR bit-16 sequence.
REQ-034 seed_load with seed = 0, then start with rate = 255, uniform = 0 -> the LFSR sequence matches SeedValue; mutation bits are 0 only where the byte = FF; crossover_mask = (1<<p)-1.
REQ-035 Hold ready = 0 for 10 cycles after valid -> masks and valid are stable; a start pulse during HOLD is ignored; ready = 1 -> IDLE the next cycle.
REQ-036 Assert rst at GEN cycle 5 -> all outputs go to 0 asynchronously; the next start produces the same masks as the first run after reset.
REQ-037 Change mutation_rate from 0 to 255 mid-GEN -> the masks reflect the rate sampled at start (all zero).
REQ-038 10,000 runs, rate = 64, Width = 32 -> mutation bit density 0.25 ± 0.01; feeding crossover_mask to the crossover/mutation stage gives consistent children against a golden model.
